// File: rtl/inst_decode_ctrl.sv
// Decode-stage control: ID/IX pipeline register, trap/RTI redirect pulses to fetch,
// and RUN/HANDLER/HALTED tracking. Define IMEM_ERR_TRAP_EN to make err_ifid_p1 trap like SIIC.
module inst_decode_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_ifid_p1,
  input  logic [15:0] pc_ifid_p1,
  input  logic        err_ifid_p1,
  input  logic        branch_taken_ixif_p1,
  output logic        illegal_op_idif_p1,
  output logic        return_execution_idif_p1,
  output logic [15:0] inst_idix_p1,
  output logic [15:0] pc_idix_p1,
  output logic        valid_idix_p1,
  output logic        in_handler_p1,
  output logic        halt_p1,
  output logic        double_fault_p1
);

  localparam logic [4:0]  OP_HALT = 5'b00000;
  localparam logic [4:0]  OP_SIIC = 5'b00010;
  localparam logic [4:0]  OP_RTI  = 5'b00011;
  localparam logic [15:0] NOP_ENC = 16'h0800;

  typedef enum logic [1:0] {ST_RUN, ST_HANDLER, ST_HALTED} state_e;

  state_e      state_q, state_d;
  logic        df_q, df_d;
  logic [15:0] inst_q, pc_q;
  logic        valid_q;

  logic [4:0] opcode;
  logic       is_halt, is_rti, is_siic, trap;
  logic       load_inst;

  assign opcode  = inst_ifid_p1[15:11];
  assign is_halt = (opcode == OP_HALT);
  assign is_rti  = (opcode == OP_RTI);
  assign is_siic = (opcode == OP_SIIC);

`ifdef IMEM_ERR_TRAP_EN
  assign trap = is_siic | err_ifid_p1;
`else
  logic unused_err;
  assign unused_err = err_ifid_p1;
  assign trap       = is_siic;
`endif

  // State register plus ID/IX pipeline register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      df_q    <= 1'b0;
      inst_q  <= NOP_ENC;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      df_q    <= df_d;
      inst_q  <= load_inst ? inst_ifid_p1 : NOP_ENC;
      pc_q    <= pc_ifid_p1 + 16'd2;
      valid_q <= load_inst;
    end
  end

  // Next-state logic; a taken branch freezes state since the IF instruction is wrong-path.
  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    df_d    = df_q;
    if (!branch_taken_ixif_p1) begin
      unique case (state_q)
        ST_RUN: begin
          if (trap)         state_d = ST_HANDLER;
          else if (is_halt) state_d = ST_HALTED;
        end
        ST_HANDLER: begin
          if (is_rti) state_d = ST_RUN;
          else if (trap) begin
            state_d = ST_HALTED;
            df_d    = 1'b1;
          end
          else if (is_halt) state_d = ST_HALTED;
        end
        default: state_d = ST_HALTED;
      endcase
    end
  end

  // Outputs: same-cycle redirect pulses and the load/bubble decision.
  always_comb begin
    illegal_op_idif_p1       = 1'b0;
    return_execution_idif_p1 = 1'b0;
    load_inst                = 1'b0;
    if (!rst && !branch_taken_ixif_p1) begin
      unique case (state_q)
        ST_RUN: begin
          illegal_op_idif_p1 = trap;
          load_inst          = !trap && !is_halt && !is_rti;
        end
        ST_HANDLER: begin
          return_execution_idif_p1 = is_rti;
          load_inst                = !is_rti && !trap && !is_halt;
        end
        default: ;
      endcase
    end
  end

  assign inst_idix_p1    = inst_q;
  assign pc_idix_p1      = pc_q;
  assign valid_idix_p1   = valid_q;
  assign in_handler_p1   = (state_q == ST_HANDLER);
  assign halt_p1         = (state_q == ST_HALTED);
  assign double_fault_p1 = df_q;

endmodule

// File: tb/tb_inst_decode_ctrl.sv
// Table-driven bench for inst_decode_ctrl: one continuous directed sequence of
// vectors with hand-computed expectations, plus a hand-written HALTED soak.
module tb_inst_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst_ifid_p1, pc_ifid_p1;
  logic        err_ifid_p1, branch_taken_ixif_p1;
  logic        illegal_op_idif_p1, return_execution_idif_p1;
  logic [15:0] inst_idix_p1, pc_idix_p1;
  logic        valid_idix_p1, in_handler_p1, halt_p1, double_fault_p1;

  always #5 clk = ~clk;

  inst_decode_ctrl dut (
    .clk                      (clk),
    .rst                      (rst),
    .inst_ifid_p1             (inst_ifid_p1),
    .pc_ifid_p1               (pc_ifid_p1),
    .err_ifid_p1              (err_ifid_p1),
    .branch_taken_ixif_p1     (branch_taken_ixif_p1),
    .illegal_op_idif_p1       (illegal_op_idif_p1),
    .return_execution_idif_p1 (return_execution_idif_p1),
    .inst_idix_p1             (inst_idix_p1),
    .pc_idix_p1               (pc_idix_p1),
    .valid_idix_p1            (valid_idix_p1),
    .in_handler_p1            (in_handler_p1),
    .halt_p1                  (halt_p1),
    .double_fault_p1          (double_fault_p1)
  );

  typedef struct {
    logic        rst, bt, err;
    logic [15:0] inst, pc;
    logic        e_ill, e_ret;
    logic [15:0] e_inst, e_pc;
    logic        chk_pc;
    logic        e_valid, e_ih, e_halt, e_df;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

`ifdef IMEM_ERR_TRAP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(logic r, logic b, logic e, logic [15:0] i, logic [15:0] p,
                              logic ill, logic ret, logic [15:0] ei, logic [15:0] ep,
                              logic cp, logic v, logic ih, logic h, logic df);
    vec_t t;
    t.rst = r; t.bt = b; t.err = e; t.inst = i; t.pc = p;
    t.e_ill = ill; t.e_ret = ret; t.e_inst = ei; t.e_pc = ep; t.chk_pc = cp;
    t.e_valid = v; t.e_ih = ih; t.e_halt = h; t.e_df = df;
    return t;
  endfunction

  // Drive at negedge, check pulses before posedge, check registers #1 after posedge.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    rst = t.rst; branch_taken_ixif_p1 = t.bt; err_ifid_p1 = t.err;
    inst_ifid_p1 = t.inst; pc_ifid_p1 = t.pc;
    #1;
    check($sformatf("v%0d illegal", idx), {15'd0, illegal_op_idif_p1}, {15'd0, t.e_ill});
    check($sformatf("v%0d return", idx), {15'd0, return_execution_idif_p1}, {15'd0, t.e_ret});
    @(posedge clk);
    #1;
    check($sformatf("v%0d inst", idx), inst_idix_p1, t.e_inst);
    if (t.chk_pc) check($sformatf("v%0d pc", idx), pc_idix_p1, t.e_pc);
    check($sformatf("v%0d valid", idx), {15'd0, valid_idix_p1}, {15'd0, t.e_valid});
    check($sformatf("v%0d in_handler", idx), {15'd0, in_handler_p1}, {15'd0, t.e_ih});
    check($sformatf("v%0d halt", idx), {15'd0, halt_p1}, {15'd0, t.e_halt});
    check($sformatf("v%0d double_fault", idx), {15'd0, double_fault_p1}, {15'd0, t.e_df});
  endtask

  initial begin
    rst = 1'b1; branch_taken_ixif_p1 = 1'b0; err_ifid_p1 = 1'b0;
    inst_ifid_p1 = 16'h0800; pc_ifid_p1 = 16'h0000;

    //            rst bt err inst     pc        ill ret e_inst   e_pc     cp v  ih h  df
    vecs.push_back(mk(1, 0, 0, 16'h1000, 16'h0010, 0, 0, 16'h0800, 16'h0000, 1, 0, 0, 0, 0)); // reset, SIIC masked
    vecs.push_back(mk(0, 0, 0, 16'h4123, 16'h0010, 0, 0, 16'h4123, 16'h0012, 1, 1, 0, 0, 0)); // ADD loads
    vecs.push_back(mk(0, 0, 0, 16'h1000, 16'h0020, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 0)); // SIIC -> HANDLER
    vecs.push_back(mk(0, 0, 0, 16'h4567, 16'h0002, 0, 0, 16'h4567, 16'h0004, 1, 1, 1, 0, 0)); // handler body
    vecs.push_back(mk(0, 0, 0, 16'h1800, 16'h0004, 0, 1, 16'h0800, 16'h0000, 0, 0, 0, 0, 0)); // RTI -> RUN
    vecs.push_back(mk(0, 0, 0, 16'h5555, 16'h0022, 0, 0, 16'h5555, 16'h0024, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h1000, 16'h0026, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 0, 0)); // flushed SIIC
    vecs.push_back(mk(0, 0, 0, 16'h1800, 16'h0028, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 0, 0)); // RTI in RUN ignored
    vecs.push_back(mk(0, 0, 0, 16'h0800, 16'h0030, 0, 0, 16'h0800, 16'h0032, 1, 1, 0, 0, 0)); // NOP valid
    vecs.push_back(mk(0, 0, 0, 16'h1000, 16'h0034, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 0)); // SIIC -> HANDLER
    vecs.push_back(mk(0, 0, 0, 16'h1000, 16'h0002, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 1)); // double fault
    vecs.push_back(mk(0, 0, 0, 16'h4123, 16'h0004, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 1)); // halted bubble
    vecs.push_back(mk(0, 0, 0, 16'h1800, 16'h0006, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 1)); // RTI no effect
    vecs.push_back(mk(1, 0, 0, 16'h1800, 16'h0008, 0, 0, 16'h0800, 16'h0000, 1, 0, 0, 0, 0)); // reset clears
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0040, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 0)); // HALT
    vecs.push_back(mk(0, 0, 0, 16'h4123, 16'h0042, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h1000, 16'h0044, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 0)); // no trap when halted
    vecs.push_back(mk(1, 0, 0, 16'h0800, 16'h0000, 0, 0, 16'h0800, 16'h0000, 1, 0, 0, 0, 0));
    // err with ordinary instruction: traps only when IMEM_ERR_TRAP_EN is defined
    vecs.push_back(mk(0, 0, 1, 16'h4123, 16'h0050, ERR_EN, 0, ERR_EN ? 16'h0800 : 16'h4123,
                      16'h0052, !ERR_EN, !ERR_EN, ERR_EN, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h1800, 16'h0002, 0, ERR_EN, 16'h0800, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h1000, 16'h0060, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h1800, 16'h0002, 0, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 0)); // flushed RTI
    vecs.push_back(mk(0, 0, 0, 16'h1800, 16'h0004, 0, 1, 16'h0800, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0070, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 0, 0)); // flushed HALT
    vecs.push_back(mk(0, 0, 0, 16'h4123, 16'hFFFE, 0, 0, 16'h4123, 16'h0000, 1, 1, 0, 0, 0)); // pc wrap
    vecs.push_back(mk(0, 0, 0, 16'h1000, 16'h0080, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0002, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 0)); // HALT in HANDLER

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand sequence: reset from HANDLER, then HALTED soak under mixed fetch traffic.
    apply(mk(1, 0, 0, 16'h0800, 16'h0000, 0, 0, 16'h0800, 16'h0000, 1, 0, 0, 0, 0), 100);
    apply(mk(0, 0, 0, 16'h1000, 16'h0090, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 0), 101);
    apply(mk(1, 0, 0, 16'h1000, 16'h0002, 0, 0, 16'h0800, 16'h0000, 1, 0, 0, 0, 0), 102);
    apply(mk(0, 0, 0, 16'h0000, 16'h00A0, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1, 0), 103);
    for (int k = 0; k < 6; k++) begin
      logic [15:0] soak_inst [6];
      soak_inst = '{16'h4123, 16'h1000, 16'h1800, 16'h0800, 16'h0000, 16'h7FFF};
      apply(mk(0, k[0], 0, soak_inst[k], 16'h00B0 + 16'(k), 0, 0, 16'h0800, 16'h0000,
               0, 0, 0, 1, 0), 110 + k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_decode_ctrl.md
# inst_decode_ctrl

Decode-stage control block sitting between fetch and execute. It consumes the instruction and PC from fetch, registers them into the ID/IX pipeline register, and drives the redirect requests back to fetch: the illegal-op trap request and the return-from-exception request. It tracks exception-handler nesting and halt state with a small state machine, and squashes wrong-path instructions on a taken branch.

## Interface
Parameters:
- none

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- inst_ifid_p1  input  16  instruction word from fetch, valid every cycle
- pc_ifid_p1  input  16  PC of inst_ifid_p1
- err_ifid_p1  input  1  instruction-memory error for inst_ifid_p1
- branch_taken_ixif_p1  input  1  execute redirect; current IF instruction is wrong-path
- illegal_op_idif_p1  output  1  trap request to fetch (combinational, one cycle)
- return_execution_idif_p1  output  1  RTI request to fetch (combinational, one cycle)
- inst_idix_p1  output  16  registered instruction to execute
- pc_idix_p1  output  16  registered pc_ifid_p1 + 2
- valid_idix_p1  output  1  registered; 0 = bubble
- in_handler_p1  output  1  state == HANDLER
- halt_p1  output  1  state == HALTED
- double_fault_p1  output  1  sticky; trap taken while in HANDLER

## Operation
- Opcode = inst_ifid_p1[15:11]. HALT = 5'b00000, NOP = 5'b00001, SIIC = 5'b00010, RTI = 5'b00011; all others pass through as ordinary instructions.
- trap = (opcode == SIIC) or (err_ifid_p1, when IMEM_ERR_TRAP_EN is defined).
- States: RUN, HANDLER, HALTED. Reset → RUN.
- Flush: if branch_taken_ixif_p1 = 1, then there is no pulse, no state change, and a bubble is loaded. This has priority over every rule below.
- RUN:
  - trap → illegal_op_idif_p1 = 1, bubble loaded, next state HANDLER.
  - HALT → bubble, next state HALTED.
  - RTI → ignored, bubble, no pulse.
  - Otherwise the instruction is loaded with valid = 1.
- HANDLER:
  - RTI → return_execution_idif_p1 = 1, bubble, next state RUN.
  - trap → double_fault_p1 set, bubble, next state HALTED, no illegal pulse.
  - HALT → HALTED.
  - Otherwise the instruction is loaded with valid = 1.
- HALTED: every cycle loads a bubble and no pulses are driven; only rst exits.
- Pulses are combinational from the current IF instruction and state, so fetch redirects on the same edge. illegal_op_idif_p1 and return_execution_idif_p1 are never high together.
- NOP loads with valid = 1; execute treats it as a no-op.
- pc_idix_p1 = pc_ifid_p1 + 16'd2, truncated to 16 bits (0xFFFE wraps to 0x0000).
- Bubble means valid_idix_p1 = 0 and inst_idix_p1 = 16'h0800 (NOP encoding).

## Timing
- Reset values:
  - inst_idix_p1 = 16'h0800, pc_idix_p1 = 0, valid_idix_p1 = 0.
  - State = RUN, so in_handler_p1 = 0 and halt_p1 = 0.
  - double_fault_p1 = 0.
  - Pulses are 0 while rst = 1.
- ID/IX register latency is 1 cycle: the IF instruction at edge N appears on the *_idix_p1 outputs after edge N.
- Each pulse lasts exactly one cycle. The following cycle's IF instruction comes from the redirect target (0x0002 or EPC) and is decoded normally.
- State transitions take effect on the same edge that loads the register.
- Reset mid-HANDLER or in HALTED: state returns to RUN and double_fault_p1 clears on the next edge.
- A trap on a cycle with branch_taken_ixif_p1 = 1 is discarded entirely.

## Configuration
- IMEM_ERR_TRAP_EN defined: err_ifid_p1 = 1 counts as a trap exactly like SIIC. This covers the illegal pulse, the HANDLER entry, and the double fault.
- IMEM_ERR_TRAP_EN undefined: err_ifid_p1 is ignored, and the instruction decodes on its opcode alone.

## Test plan
- Reset, then feed ADD-class 16'h4123 at PC 0x0010 → one cycle later inst_idix_p1 = 0x4123, pc_idix_p1 = 0x0012, valid = 1; no pulses.
- SIIC 16'h1000 at PC 0x0020 in RUN → illegal_op_idif_p1 = 1 that cycle, next valid = 0, in_handler_p1 = 1. Then RTI 16'h1800 → return_execution_idif_p1 = 1 and in_handler_p1 returns to 0.
- SIIC in RUN with branch_taken_ixif_p1 = 1 → no pulse, state stays RUN, valid = 0.
- SIIC while in HANDLER → no pulse, double_fault_p1 = 1, halt_p1 = 1. Subsequent ordinary instructions give valid = 0. After rst, all outputs return to reset values.
- HALT 16'h0000 → halt_p1 = 1 next cycle, and valid stays 0 while fetch keeps supplying instructions. RTI in RUN → no pulse, valid = 0.
- err_ifid_p1 = 1 with 16'h4123: with IMEM_ERR_TRAP_EN, illegal_op_idif_p1 = 1 and state goes to HANDLER. Without it, 0x4123 is loaded with valid = 1.
